// File: rtl/shift_defs_pkg.sv
// Shared definitions for the sequential shift unit.
// Function codes, FSM state encoding and small code-class helpers.
package shift_defs;

  localparam logic [2:0] FN_NOP  = 3'b000;
  localparam logic [2:0] FN_LOAD = 3'b001;
  localparam logic [2:0] FN_SLL  = 3'b010;
  localparam logic [2:0] FN_SRL  = 3'b011;
  localparam logic [2:0] FN_SRA  = 3'b100;
  localparam logic [2:0] FN_ROR  = 3'b101;
  localparam logic [2:0] FN_ROL  = 3'b110;
  localparam logic [2:0] FN_RSV  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Codes that need per-bit SHIFT residency.
  function automatic logic is_shift(
    input logic [2:0] fn
  );
    logic r;
    r = 1'b0;
    unique case (fn)
      FN_SLL,
      FN_SRL,
      FN_SRA,
      FN_ROR,
      FN_ROL:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mux_func_src_sel.sv
// N:1 selector of packed 3-bit function codes.
// Ports: func_sel (index), func_src (N packed codes), func (selected code).
module mux_func_src_sel #(
  parameter int N_FUNC_SRC = 4,
  parameter int SEL_W      = 2
) (
  input  logic [SEL_W-1:0]        func_sel,
  input  logic [N_FUNC_SRC*3-1:0] func_src,
  output logic [2:0]              func
);

  // Out-of-range selects fall through to source 0.
  always_comb begin
    func = func_src[2:0];
    for (int k = 1; k < N_FUNC_SRC; k++) begin
      if (func_sel == SEL_W'(k)) begin
        func = func_src[3*k +: 3];
      end
    end
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shift unit: LOAD/shift/rotate, one bit per clock.
// Ports: clk, reset, func_sel, func_src, shamt, data_in, start in;
//        busy, done, data_out out.
module shift_seq_unit
  import shift_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int N_FUNC_SRC = 4,
  parameter int SEL_W      = 2,
  parameter int SHAMT_W    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        func_sel,
  input  logic [N_FUNC_SRC*3-1:0] func_src,
  input  logic [SHAMT_W-1:0]      shamt,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        data_out
);

  logic [2:0]         sel_func;

  state_e             state_q;
  state_e             state_d;
  logic [2:0]         func_q;
  logic [2:0]         func_d;
  logic [SHAMT_W-1:0] cnt_q;
  logic [SHAMT_W-1:0] cnt_d;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   data_d;

  mux_func_src_sel #(
    .N_FUNC_SRC (N_FUNC_SRC),
    .SEL_W      (SEL_W)
  ) u_func_mux (
    .func_sel (func_sel),
    .func_src (func_src),
    .func     (sel_func)
  );

  // One-bit step of the latched operation.
  function automatic logic [WIDTH-1:0] step1(
    input logic [2:0]       fn,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (fn)
      FN_SLL:  r = {d[WIDTH-2:0], 1'b0};
      FN_SRL:  r = {1'b0, d[WIDTH-1:1]};
      FN_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      FN_ROR:  r = {d[0], d[WIDTH-1:1]};
      FN_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d = sel_func;
          cnt_d  = shamt;
          if (sel_func == FN_LOAD) begin
            data_d = data_in;
          end
          // Zero-length shifts finish like NOP.
          if (is_shift(sel_func) && (shamt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        data_d = step1(func_q, data_q);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      func_q  <= FN_NOP;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign data_out = data_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: directed and random ops
// against an arithmetic reference model.
module tb_shift_seq_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  func_sel;
  logic [11:0] func_src;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  logic [1:0]  sel3;
  logic [8:0]  src3;
  logic [4:0]  shamt3;
  logic [31:0] din3;
  logic        start3;
  logic        busy3;
  logic        done3;
  logic [31:0] dout3;

  int tests;
  int fails;
  logic [31:0] model_reg;

  shift_seq_unit #(
    .WIDTH(32), .N_FUNC_SRC(4), .SEL_W(2), .SHAMT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .func_sel(func_sel),
    .func_src(func_src), .shamt(shamt), .data_in(data_in),
    .start(start), .busy(busy), .done(done), .data_out(data_out)
  );

  shift_seq_unit #(
    .WIDTH(32), .N_FUNC_SRC(3), .SEL_W(2), .SHAMT_W(5)
  ) dut3 (
    .clk(clk), .reset(reset), .func_sel(sel3),
    .func_src(src3), .shamt(shamt3), .data_in(din3),
    .start(start3), .busy(busy3), .done(done3), .data_out(dout3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] c,
      input logic [31:0] d, input int s, input logic [31:0] din);
    logic [31:0] r;
    case (c)
      3'd1: r = din;
      3'd2: r = d << s;
      3'd3: r = d >> s;
      3'd4: r = 32'($signed(d) >>> s);
      3'd5: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
      3'd6: r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic bit shifty(input logic [2:0] c);
    return (c >= 3'd2) && (c <= 3'd6);
  endfunction

  // One operation: start pulse, watch busy/partials, check done timing.
  task automatic do_op(input logic [2:0] code, input logic [1:0] sel,
      input logic [4:0] sa, input logic [31:0] din, input bit poke);
    logic [11:0] src;
    logic [31:0] prev;
    int lat;
    int n;
    int dones;
    prev = model_reg;
    src = 12'($urandom);
    src[3*sel +: 3] = code;
    lat = (shifty(code) && sa != 0) ? int'(sa) + 1 : 1;
    @(negedge clk);
    func_sel = sel; func_src = src; shamt = sa;
    data_in = din; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    func_src = 12'($urandom); shamt = 5'($urandom);
    data_in = $urandom; func_sel = 2'($urandom);
    n = 1;
    dones = 0;
    while (!done && n < 40) begin
      chk("busy_shift", {63'd0, busy}, 64'd1);
      if (shifty(code))
        chk("partial", {32'd0, data_out},
            {32'd0, ref_op(code, prev, n - 1, din)});
      if (poke) begin
        start = 1'b1; func_src = {4{3'b001}}; data_in = 32'hDEADBEEF;
      end
      @(negedge clk);
      n++;
    end
    if (done) dones++;
    chk("latency", 64'(n), 64'(lat));
    chk("busy_done", {63'd0, busy}, 64'd1);
    model_reg = ref_op(code, prev, int'(sa), din);
    chk("result", {32'd0, data_out}, {32'd0, model_reg});
    if (poke) begin
      start = 1'b1; func_src = {4{3'b001}}; data_in = 32'hDEADBEEF;
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("hold", {32'd0, data_out}, {32'd0, model_reg});
    chk("one_done", 64'(dones), 64'd1);
  endtask

  initial begin
    int seen;
    logic [2:0] c;
    tests = 0; fails = 0; model_reg = '0;
    reset = 1'b1; start = 1'b0; func_sel = '0; func_src = '0;
    shamt = '0; data_in = '0;
    start3 = 1'b0; sel3 = '0; src3 = '0; shamt3 = '0; din3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_data", {32'd0, data_out}, 64'd0);
    reset = 1'b0;

    do_op(3'b001, 2'd1, 5'd3, 32'h8000_0001, 1'b0);
    do_op(3'b001, 2'd0, 5'd0, 32'h8000_0000, 1'b0);
    do_op(3'b100, 2'd2, 5'd4, 32'h0, 1'b0);
    chk("sra_val", {32'd0, data_out}, 64'hF800_0000);
    do_op(3'b001, 2'd3, 5'd0, 32'h8000_0001, 1'b0);
    do_op(3'b110, 2'd1, 5'd1, 32'h0, 1'b0);
    chk("rol_val", {32'd0, data_out}, 64'h0000_0003);
    do_op(3'b001, 2'd0, 5'd9, 32'h0000_0001, 1'b0);
    do_op(3'b101, 2'd3, 5'd31, 32'h0, 1'b0);
    chk("ror_val", {32'd0, data_out}, 64'h0000_0002);
    do_op(3'b001, 2'd2, 5'd0, 32'h1234_5678, 1'b0);
    do_op(3'b010, 2'd1, 5'd0, 32'h0, 1'b0);
    do_op(3'b111, 2'd0, 5'd7, 32'hFFFF_FFFF, 1'b0);
    chk("rsv_val", {32'd0, data_out}, 64'h1234_5678);
    do_op(3'b001, 2'd1, 5'd0, 32'hFF00_0000, 1'b0);
    do_op(3'b011, 2'd2, 5'd8, 32'h0, 1'b1);
    chk("srl_val", {32'd0, data_out}, 64'h00FF_0000);

    for (int i = 0; i < 40; i++) begin
      c = 3'($urandom);
      do_op(c, 2'($urandom), 5'($urandom), $urandom, 1'($urandom));
    end

    // Reset mid-SHIFT.
    do_op(3'b001, 2'd0, 5'd0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    func_sel = 2'd0; func_src = 12'b011; shamt = 5'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reg = '0;
    chk("rst_mid_data", {32'd0, data_out}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'd0);

    // Out-of-range select on the 3-source instance uses source 0.
    @(negedge clk);
    sel3 = 2'd3; src3 = {3'b010, 3'b010, 3'b001};
    din3 = 32'hA5A5_0F0F; shamt3 = 5'd5; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("sel_oor_done", {63'd0, done3}, 64'd1);
    chk("sel_oor_data", {32'd0, dout3}, 64'hA5A5_0F0F);
    @(negedge clk);
    chk("sel_oor_idle", {63'd0, busy3}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Parametrised sequential shift unit for the multicycle datapath.
- Selects a 3-bit shift function code from N packed sources; the selector generalises the 4:1 function-source mux to any source count.
- Executes LOAD, shift and rotate operations on an internal WIDTH-bit register, one bit position per clock.
- Uses a start/busy/done handshake so the control FSM can sequence variable-latency shifts.

Parameters:
- WIDTH, 32, data register width in bits (>= 2).
- N_FUNC_SRC, 4, number of function-code sources (>= 1).
- SEL_W, 2, width of func_sel; must satisfy 2**SEL_W >= N_FUNC_SRC.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W <= WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- func_sel  in  SEL_W  function-source select.
- func_src  in  N_FUNC_SRC*3  packed function codes; source k occupies bits [3k+2:3k].
- shamt  in  SHAMT_W  shift amount, sampled with start.
- data_in  in  WIDTH  load value for LOAD.
- start  in  1  request; accepted only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse; data_out is final in that cycle.
- data_out  out  WIDTH  internal shift register contents.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state <= IDLE; data_out, counter and latched func <= 0; busy = 0; done = 0. Reset wins over every other input, including mid-operation; no done pulse follows.
- Function select:
  - func = func_src[3*func_sel +: 3].
  - func_sel >= N_FUNC_SRC selects source 0.
  - Sampled only at start acceptance; later changes have no effect.
- Codes:
  - 000 NOP (register unchanged).
  - 001 LOAD (data_out <= data_in).
  - 010 SLL, zero fill.
  - 011 SRL, zero fill.
  - 100 SRA, MSB replicated.
  - 101 ROR.
  - 110 ROL.
  - 111 reserved, executes as NOP.
- States: IDLE, SHIFT, DONE.
- IDLE, with start=1 at the edge ending cycle T:
  - Latch func; cnt <= shamt.
  - LOAD: data_out <= data_in in the same edge.
  - Shift/rotate with shamt != 0: next state SHIFT.
  - Otherwise (NOP, LOAD, 111, or shamt == 0): next state DONE; data_out unchanged except LOAD.
- SHIFT:
  - Each edge applies a 1-bit operation per the latched func and decrements cnt.
  - When cnt == 1 at the edge, next state is DONE.
  - Residency is exactly shamt cycles.
- DONE: done = 1 for exactly one cycle; next state IDLE.
- Latency: start at T, done at T+shamt+1 for shifts and T+1 for the others. Back-to-back start is accepted earliest in the cycle after done.
- start while busy (SHIFT or DONE) is ignored and not queued.
- data_out holds its value in IDLE and reflects partial results during SHIFT.
- Outputs are registered-state decodes; there is no combinational path from inputs to busy, done or data_out.

Decomposition:
- Shared package/include shift_defs:
  - function-code localparams (FN_NOP, FN_LOAD, FN_SLL, FN_SRL, FN_SRA, FN_ROR, FN_ROL);
  - state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2).
- One sub-module: mux_func_src_sel, a combinational N:1 selector of 3-bit fields, parametrised by N_FUNC_SRC and SEL_W, with out-of-range mapped to source 0.
- The FSM, counter and datapath stay in shift_seq_unit.

Test Plan:
- LOAD via func_sel=1, func_src[5:3]=001, data_in=0x8000_0001, start at T -> done at T+1, data_out=0x8000_0001, busy high only in T+1.
- Then SRA shamt=4 on 0x8000_0000 (loaded first) -> busy T+1..T+5, done at T+5, data_out=0xF800_0000; after 2 SHIFT edges data_out=0xE000_0000.
- ROL shamt=1 on 0x8000_0001 -> 0x0000_0003 with done at T+2. ROR shamt=31 on 0x0000_0001 -> 0x0000_0002 with done at T+32.
- SLL shamt=0 on 0x1234_5678 -> done at T+1, data_out unchanged. Code 111 shamt=7 -> done at T+1, unchanged.
- SRL shamt=8 on 0xFF00_0000, second start (LOAD 0xDEAD_BEEF) pulsed in SHIFT and in DONE -> both ignored; result 0x00FF_0000, one done pulse only.
- Reset asserted mid-SHIFT: next cycle data_out=0, busy=0, done=0, no done pulse. Separately, func_sel=3 with N_FUNC_SRC=3 -> source 0 code is used.
